// File: rtl/apb_regfile_slave.sv
// APB completer around a flop-based DATA_W x DEPTH register file with wait states and decode errors.
// Optional byte-lane strobes are enabled by defining APB_REGFILE_PSTRB_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no transfer in flight; waits for a setup phase
// S_WAIT | access phase, counting down the programmed wait states
// S_RESP | pready high with registered response; completes on penable
module apb_regfile_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BYTES = DEPTH * NB;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state, state_d;
    logic [3:0]         cnt, cnt_d;
    logic               latch, enter_resp, clear, do_write;

    logic               wr_q, valid_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [NB-1:0]      strb_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               aligned, addr_ok, valid_in;
    logic [IDX_W-1:0]   idx_in;
    logic [NB-1:0]      strb_in;

    logic               rd_valid, rd_wr;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  resp_data;

    if (LSB > 0) begin : g_align
        assign aligned = (paddr[LSB-1:0] == '0);
    end else begin : g_noalign
        assign aligned = 1'b1;
    end

    assign idx_in  = paddr[LSB +: IDX_W];
    assign addr_ok = (paddr < ADDR_W'(BYTES)) && aligned;

`ifdef APB_REGFILE_PSTRB_EN
    assign strb_in  = pstrb;
    // reads carrying strobes are rejected
    assign valid_in = addr_ok && (pwrite || (pstrb == '0));
`else
    assign strb_in  = '1;
    assign valid_in = addr_ok;
`endif

    // Zero-wait transfers enter RESP on the setup edge, before the latches settle.
    assign rd_valid  = (state == S_IDLE) ? valid_in : valid_q;
    assign rd_wr     = (state == S_IDLE) ? pwrite   : wr_q;
    assign rd_idx    = (state == S_IDLE) ? idx_in   : idx_q;
    assign resp_data = (rd_valid && !rd_wr) ? mem[rd_idx] : '0;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        latch      = 1'b0;
        enter_resp = 1'b0;
        clear      = 1'b0;
        do_write   = 1'b0;
        case (state)
            S_IDLE: begin
                if (psel && !penable) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end else if (cnt == '0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    clear   = 1'b1;
                end else if (penable) begin
                    state_d  = S_IDLE;
                    clear    = 1'b1;
                    do_write = wr_q && valid_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                clear   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (latch) begin
                wr_q    <= pwrite;
                valid_q <= valid_in;
                idx_q   <= idx_in;
                wdata_q <= pwdata;
                strb_q  <= strb_in;
            end
            if (enter_resp) begin
                pready  <= 1'b1;
                pslverr <= !rd_valid;
                prdata  <= resp_data;
            end else if (clear) begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
                prdata  <= '0;
            end
            if (do_write) begin
                for (int b = 0; b < NB; b++) begin
                    if (strb_q[b]) begin
                        mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench: two instances (0 and 3 wait states) driven by directed APB transfers.
module tb_apb_regfile_slave;

    localparam int W1 = 3;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic [1:0]        preset, psel, penable, pwrite, pready, pslverr;
    logic [1:0][31:0]  paddr, pwdata, prdata;
`ifdef APB_REGFILE_PSTRB_EN
    logic [1:0][3:0]   pstrb;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] expq [2][$];
    logic [31:0] model [2][16];
    logic [32:0] e;

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_REGFILE_PSTRB_EN
        .pstrb(pstrb[0]),
`endif
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(W1)) u_dut1 (
        .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_REGFILE_PSTRB_EN
        .pstrb(pstrb[1]),
`endif
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response cycle pops one expected {pslverr, prdata}.
    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            if (!preset[d] && pready[d]) begin
                if (expq[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp dut%0d: got pready=1 expected no response", d);
                end else begin
                    e = expq[d].pop_front();
                    check($sformatf("prdata_dut%0d", d), prdata[d], e[31:0]);
                    check($sformatf("pslverr_dut%0d", d), {31'b0, pslverr[d]}, {31'b0, e[32]});
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the completion edge with psel still high.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic exp_err);
        int cyc;
        logic [3:0] eff;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
`ifdef APB_REGFILE_PSTRB_EN
        pstrb[d] = strb;
        eff      = strb;
`else
        eff      = 4'hF | strb;
`endif
        expq[d].push_back({exp_err, exp_rd});
        if (wr && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (eff[b]) model[d][addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        paddr[d]   = ~addr;
        pwdata[d]  = ~data;
        pwrite[d]  = ~wr;
        cyc = 0;
        while (!pready[d] && cyc < 20) begin
            @(posedge pclk); #1;
            cyc++;
        end
        check($sformatf("latency_dut%0d_addr%0h", d, addr), cyc, (d == 0) ? 0 : W1);
        @(posedge pclk); #1;
    endtask

    task automatic idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic chk_idle(input int d, input string tag);
        check($sformatf("%s_prdata_dut%0d", tag, d), prdata[d], 32'h0);
        check($sformatf("%s_pready_dut%0d", tag, d), {31'b0, pready[d]}, 32'h0);
        check($sformatf("%s_pslverr_dut%0d", tag, d), {31'b0, pslverr[d]}, 32'h0);
    endtask

    task automatic start_write(input int d, input logic [31:0] addr, input logic [31:0] data);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = 1'b1;
        paddr[d]   = addr;
        pwdata[d]  = data;
`ifdef APB_REGFILE_PSTRB_EN
        pstrb[d] = 4'hF;
`endif
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        preset  = 2'b11;
        psel    = '0;
        penable = '0;
        pwrite  = '0;
        paddr   = '0;
        pwdata  = '0;
`ifdef APB_REGFILE_PSTRB_EN
        pstrb   = '0;
`endif
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
        repeat (3) @(posedge pclk);
        #1 preset = 2'b00;
        chk_idle(0, "reset");
        chk_idle(1, "reset");
        @(posedge pclk); #1;

        // zero-wait write/read
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);        idle(0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);        idle(0);
        // back-to-back write then read
        xfer(0, 1'b1, 32'h0C, 32'hA5A50F0F, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 32'hA5A50F0F, 1'b0);        idle(0);
        // decode errors
        xfer(0, 1'b1, 32'h40, 32'hBAD0BAD0, 4'hF, 32'h0, 1'b1);        idle(0);
        xfer(0, 1'b1, 32'h02, 32'hBAD1BAD1, 4'hF, 32'h0, 1'b1);        idle(0);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1);               idle(0);
        xfer(0, 1'b0, 32'h0E, 32'h0, 4'h0, 32'h0, 1'b1);               idle(0);
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, model[0][i], 1'b0);
            idle(0);
        end
`ifdef APB_REGFILE_PSTRB_EN
        xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);        idle(0);
        xfer(0, 1'b1, 32'h10, 32'h00000000, 4'b0101, 32'h0, 1'b0);     idle(0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hFF00FF00, 1'b0);        idle(0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b0001, 32'h0, 1'b1);            idle(0);
`endif

        // three wait states
        xfer(1, 1'b1, 32'h3C, 32'h12345678, 4'hF, 32'h0, 1'b0);        idle(1);
        xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, 32'h12345678, 1'b0);        idle(1);
        xfer(1, 1'b1, 32'h04, 32'h11112222, 4'hF, 32'h0, 1'b0);        idle(1);

        // abort by dropping psel during WAIT
        start_write(1, 32'h04, 32'h99999999);
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        @(posedge pclk); #1;
        chk_idle(1, "abort");
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 32'h11112222, 1'b0);        idle(1);

        // reset during a write: nothing lands, everything clears
        start_write(1, 32'h08, 32'h77777777);
        preset[1] = 1'b1;
        #1;
        chk_idle(1, "reset_mid");
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        @(posedge pclk); #1;
        preset[1] = 1'b0;
        @(posedge pclk); #1;
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 1'b0);               idle(1);
        xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, 32'h0, 1'b0);               idle(1);

        repeat (2) @(posedge pclk);
        for (int d = 0; d < 2; d++) begin
            if (expq[d].size() != 0) begin
                checks++;
                errors++;
                $display("FAIL pending_resp dut%0d: got %0d outstanding expected 0", d, expq[d].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB completer wrapping a flop-based register file, the next generation of the team's fixed 16×32 APB slave. It adds configurable data width and depth, programmable wait states, address decode with error response, and optional byte-lane write strobes. It sits behind the APB bridge as a generic scratch/config register bank for peripheral subsystems.

## Interface
- DATA_W, 32, data bus width in bits; one of 8, 16, 32 or 64.
- ADDR_W, 32, APB address width.
- DEPTH, 16, number of DATA_W-bit registers; power of two, at least 2.
- WAIT_CYCLES, 0, wait states inserted in every access phase; range 0–15.
- pclk  input  1  clock; all logic on rising edge.
- preset  input  1  asynchronous, active-high reset.
- psel  input  1  slave select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  byte address.
- pwdata  input  DATA_W  write data.
- pstrb  input  DATA_W/8  byte-lane write strobes; present only with APB_REGFILE_PSTRB_EN.
- prdata  output  DATA_W  read data.
- pready  output  1  transfer-complete indicator.
- pslverr  output  1  error response, valid when pready=1.

## Operation
- LSB = log2(DATA_W/8). Register index = paddr[LSB +: log2(DEPTH)].
- An address is valid iff paddr < DEPTH·DATA_W/8 and paddr[LSB-1:0] = 0 (the alignment check applies only when DATA_W > 8).
- FSM states: IDLE, WAIT, RESP.
- IDLE: when psel=1 and penable=0 (setup phase), latch pwrite, the index, the valid flag and pwdata/pstrb. Then:
  - if WAIT_CYCLES = 0, go to RESP;
  - otherwise load the wait counter with WAIT_CYCLES−1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
- Transition into RESP:
  - set pready=1 and pslverr = !valid;
  - for a valid read, prdata = mem[index];
  - for an invalid read or any write, prdata = 0.
- RESP: the transfer completes on the first edge with psel=1 and penable=1.
  - A valid write commits on that edge.
  - An invalid write leaves memory unchanged.
  - Then go to IDLE and clear pready, pslverr and prdata.
- Abort: if psel=0 in WAIT or RESP, go to IDLE, perform no write and clear the outputs.
- penable=1 while in IDLE is ignored; the FSM stays in IDLE.
- Back-to-back transfers: a new setup phase is accepted in the IDLE cycle that immediately follows completion.

## Timing
- Reset (asynchronous assert, synchronous-safe release): FSM → IDLE, counter → 0, prdata → 0, pready → 0, pslverr → 0, all registers → 0.
- Reset mid-transfer aborts it; no partial write occurs.
- Transfer length is 2 + WAIT_CYCLES cycles from setup to completion. pready rises at the start of the access phase plus WAIT_CYCLES cycles.
- prdata and pslverr are registered and stable for the whole cycle in which pready=1.
- A write is visible to a read whose setup phase starts on the cycle after the write completes.
- The response (pready, pslverr, prdata) depends only on the latched address and data. Changes on paddr, pwdata or pwrite after setup are ignored.

## Configuration
- APB_REGFILE_PSTRB_EN defined:
  - the pstrb port exists;
  - a valid write updates only the bytes whose strobe is 1;
  - a read with pstrb ≠ 0 completes with pslverr=1, prdata=0 (APB4 rule).
- Not defined:
  - there is no pstrb port;
  - every valid write updates the full word.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x08 and read 0x08 with WAIT_CYCLES=0 → each transfer takes 2 cycles; the read returns 0xDEADBEEF with pslverr=0.
- WAIT_CYCLES=3, read address 0x3C after writing 0x12345678 there → pready stays low for 3 access cycles, then the read returns 0x12345678.
- Write to 0x40 (DEPTH=16, DATA_W=32) and to the misaligned address 0x02 → pslverr=1 for both; a read of every register shows no change.
- With the macro, write 0xFFFFFFFF then write 0x00000000 with pstrb=4'b0101 → a readback returns 0xFF00FF00.
- Drop psel during the WAIT state of a write to 0x04, and separately assert preset mid-write → the register reads back its old value and the outputs return to 0.
- Back-to-back write then read of 0x0C with no idle gap → the read returns the written data.
